// File: rtl/dac_stream_seq_pkg.sv
// Shared types and default sizing for the DAC sample sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dac_stream_seq_pkg;

    // Default sizing picked up by the SoC top
    localparam int DEF_DATA_W = 10;
    localparam int DEF_NCH    = 2;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_DIV_W  = 16;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    // Channel pointer width; a single channel still needs a 1-bit pointer
    function automatic int ch_ptr_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Sample buffer: circular FIFO with registered occupancy count.
// Latency: write visible on rd_data the cycle after push; rd_data shows head combinationally.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with fill.
module seq_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && (fill != FULL_LVL);
    assign do_pop  = pop && (fill != '0);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Storage array carries no reset; contents are meaningless while fill is zero
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dac_stream_seq.sv
// Streams buffered samples round-robin onto NCH DAC channels at a programmable tick rate.
// Latency: a popped sample reaches dac_code one CLK after its tick.
// Backpressure: in_ready drops when the FIFO holds DEPTH samples; underrun zeroes or holds codes.
module dac_stream_seq
    import dac_stream_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NCH    = DEF_NCH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     hold_mode,
    input  logic [DIV_W-1:0]         div,
    input  logic [$clog2(DEPTH):0]   prime_lvl,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NCH*DATA_W-1:0]    dac_code,
    output logic [NCH-1:0]           dac_upd,
    output logic                     dac_clk_en,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = ch_ptr_w(NCH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [DIV_W-1:0]  tick_cnt;
    logic [CW-1:0]     ch_ptr;
    logic              was_active;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              tick;
    logic              pop;
    logic              starve;

    assign in_ready   = (fill < FULL_LVL);
    assign push       = in_valid && in_ready;
    // >= rather than == so that shrinking div below the current count still wraps
    assign tick       = (state == RUN) && (tick_cnt >= div);
    assign pop        = tick && (fill != '0);
    assign starve     = tick && (fill == '0);
    // Keep the DAC clock alive one extra cycle so the final code update lands
    assign dac_clk_en = (state != IDLE) || was_active;

    seq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (head_data),
        .fill    (fill)
    );

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: dropping enable always wins; underrun falls back to re-priming
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) state_nxt = PRIME;
            end
            PRIME: begin
                if (!enable)                state_nxt = IDLE;
                else if (fill >= prime_lvl) state_nxt = RUN;
            end
            RUN: begin
                if (!enable)    state_nxt = IDLE;
                else if (starve) state_nxt = PRIME;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Rate divider: free-runs 0..div in RUN, parked at zero elsewhere
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)                      tick_cnt <= '0;
        else if ((state != RUN) || tick)   tick_cnt <= '0;
        else                               tick_cnt <= tick_cnt + DIV_W'(1);
    end

    // Remembers whether the previous cycle was active, for the clock-enable tail
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) was_active <= 1'b0;
        else          was_active <= (state != IDLE);
    end

    // Sticky underrun, cleared only when a new run is requested from IDLE
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)                     underrun <= 1'b0;
        else if ((state == IDLE) && enable) underrun <= 1'b0;
        else if (starve)                  underrun <= 1'b1;
    end

    // Channel demux: pops go round-robin; an underrun restarts at channel 0
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            dac_code <= '0;
            dac_upd  <= '0;
            ch_ptr   <= '0;
        end else begin
            dac_upd <= '0;
            if (pop) begin
                for (int i = 0; i < NCH; i++) begin
                    if (ch_ptr == CW'(i)) begin
                        dac_code[i*DATA_W +: DATA_W] <= head_data;
                        dac_upd[i]                   <= 1'b1;
                    end
                end
                ch_ptr <= (ch_ptr == CW'(NCH-1)) ? '0 : ch_ptr + CW'(1);
            end else if (starve) begin
                ch_ptr <= '0;
                if (!hold_mode) begin
                    dac_code <= '0;
                    dac_upd  <= '1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_stream_seq.sv
// Self-checking bench for dac_stream_seq against a queue-based reference model.
// Latency: model predicts outputs one CLK after inputs are applied.
// Backpressure: model tracks in_ready from its own queue occupancy.
module tb_dac_stream_seq;

    localparam int DATA_W = 10;
    localparam int NCH    = 2;
    localparam int DEPTH  = 8;
    localparam int DIV_W  = 16;
    localparam int AW     = $clog2(DEPTH);

    localparam int S_IDLE  = 0;
    localparam int S_PRIME = 1;
    localparam int S_RUN   = 2;

    logic                  CLK = 1'b0;
    logic                  reset_n;
    logic                  enable;
    logic                  hold_mode;
    logic [DIV_W-1:0]      div;
    logic [AW:0]           prime_lvl;
    logic [DATA_W-1:0]     in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [NCH*DATA_W-1:0] dac_code;
    logic [NCH-1:0]        dac_upd;
    logic                  dac_clk_en;
    logic                  underrun;
    logic [AW:0]           fill;

    always #5 CLK = ~CLK;

    dac_stream_seq #(
        .DATA_W (DATA_W),
        .NCH    (NCH),
        .DEPTH  (DEPTH),
        .DIV_W  (DIV_W)
    ) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .enable     (enable),
        .hold_mode  (hold_mode),
        .div        (div),
        .prime_lvl  (prime_lvl),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dac_code   (dac_code),
        .dac_upd    (dac_upd),
        .dac_clk_en (dac_clk_en),
        .underrun   (underrun),
        .fill       (fill)
    );

    // Reference model state
    int                m_st;
    int                m_phase;
    int                m_ch;
    bit                m_under;
    bit                m_was_on;
    logic [DATA_W-1:0] m_code [NCH];
    logic [NCH-1:0]    m_upd;
    logic [DATA_W-1:0] m_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [NCH-1:0]        log_upd  [$];
    logic [NCH*DATA_W-1:0] log_code [$];
    int                    log_cyc  [$];
    logic [DATA_W-1:0]     sent     [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NCH*DATA_W-1:0] exp_code();
        logic [NCH*DATA_W-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*DATA_W +: DATA_W] = m_code[i];
        return r;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_phase = 0; m_ch = 0; m_under = 0; m_was_on = 0;
        m_upd = '0;
        m_q.delete();
        foreach (m_code[i]) m_code[i] = '0;
    endtask

    // Advance the model across one rising edge using the inputs now applied
    task automatic model_step();
        int sz;
        bit tk;
        sz = m_q.size();
        tk = (m_st == S_RUN) && (m_phase >= int'(div));
        m_upd = '0;
        if (tk && sz > 0) begin
            m_code[m_ch] = m_q.pop_front();
            m_upd[m_ch]  = 1'b1;
            m_ch = (m_ch + 1) % NCH;
        end else if (tk) begin
            m_under = 1'b1;
            m_ch    = 0;
            if (!hold_mode) begin
                foreach (m_code[i]) m_code[i] = '0;
                m_upd = '1;
            end
        end
        if (in_valid && sz < DEPTH) m_q.push_back(in_data);
        m_phase  = (m_st == S_RUN && !tk) ? m_phase + 1 : 0;
        m_was_on = (m_st != S_IDLE);
        case (m_st)
            S_IDLE:  if (enable) begin m_st = S_PRIME; m_under = 1'b0; end
            S_PRIME: if (!enable) m_st = S_IDLE; else if (sz >= int'(prime_lvl)) m_st = S_RUN;
            default: if (!enable) m_st = S_IDLE; else if (tk && sz == 0) m_st = S_PRIME;
        endcase
    endtask

    task automatic compare_all();
        chk("fill",       fill,       m_q.size());
        chk("in_ready",   in_ready,   m_q.size() < DEPTH);
        chk("dac_code",   dac_code,   exp_code());
        chk("dac_upd",    dac_upd,    m_upd);
        chk("underrun",   underrun,   m_under);
        chk("dac_clk_en", dac_clk_en, (m_st != S_IDLE) || m_was_on);
    endtask

    task automatic check_reset_values();
        chk("rst_fill",     fill,       0);
        chk("rst_in_ready", in_ready,   1);
        chk("rst_dac_code", dac_code,   0);
        chk("rst_dac_upd",  dac_upd,    0);
        chk("rst_underrun", underrun,   0);
        chk("rst_clk_en",   dac_clk_en, 0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        cyc++;
        compare_all();
        if (dac_upd != '0) begin
            log_upd.push_back(dac_upd);
            log_code.push_back(dac_code);
            log_cyc.push_back(cyc);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_logs();
        log_upd.delete(); log_code.delete(); log_cyc.delete();
    endtask

    // Called just after an edge: pulls reset mid-cycle and checks it acts at once
    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1 check_reset_values();
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        bit accepted;
        logic [NCH*DATA_W-1:0] tmp;
        int ch;
        int npop;
        int vprob;

        reset_n = 1'b1; enable = 0; hold_mode = 0; div = '0; prime_lvl = 1;
        in_data = '0; in_valid = 0;
        #1 reset_n = 1'b0;
        #2 check_reset_values();
        model_reset();
        @(posedge CLK);
        #2 reset_n = 1'b1;

        // Basic streaming, then drain into a zeroing underrun
        enable = 1; div = 3; prime_lvl = 4; hold_mode = 0;
        clear_logs();
        c0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_data = DATA_W'(i);
            cycle();
        end
        in_valid = 0;
        run(30);
        chk("a_upd_count", log_upd.size(), 5);
        if (log_cyc.size() > 0) chk("a_first_latency", log_cyc[0] - c0, 9);
        for (int k = 0; k < 4 && k < log_upd.size(); k++) begin
            tmp = log_code[k];
            chk("a_upd_bit", log_upd[k], 1 << (k % 2));
            chk("a_code", tmp[(k % 2)*DATA_W +: DATA_W], k + 1);
            if (k > 0) chk("a_tick_gap", log_cyc[k] - log_cyc[k-1], 4);
        end
        if (log_upd.size() > 4) chk("a_ur_upd_all", log_upd[4], {NCH{1'b1}});
        chk("a_ur_flag", underrun, 1);
        chk("a_ur_codes", dac_code, 0);

        // Re-enable clears underrun; hold-mode underrun keeps codes
        enable = 0; cycle();
        enable = 1; cycle();
        chk("b_ur_cleared", underrun, 0);
        hold_mode = 1;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_data  = (i == 3) ? 10'h344 : DATA_W'(10'h111 * (i + 1));
            cycle();
        end
        in_valid = 0;
        run(30);
        chk("b_upd_count", log_upd.size(), 4);
        chk("b_held_codes", dac_code, {10'h344, 10'h333});
        chk("b_ur_flag", underrun, 1);

        // Fill to DEPTH; 9th sample waits for the first pop
        hold_mode = 0; prime_lvl = DEPTH; div = 5;
        clear_logs();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_data = DATA_W'(10'h200 + i);
            cycle();
        end
        chk("c_full_fill", fill, DEPTH);
        chk("c_full_ready", in_ready, 0);
        in_data = 10'h2FF;
        accepted = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = in_ready;
            if (accepted) chk("c_push9_after_pop", log_upd.size(), 1);
            cycle();
        end
        in_valid = 0;
        chk("c_push9_bound", accepted, 1);
        run(70);

        // Push exactly on ticks with fill=3: occupancy stays put, order preserved
        prime_lvl = 3; div = 3;
        clear_logs(); sent.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = DATA_W'(10'h050 + i);
            sent.push_back(in_data);
            cycle();
        end
        in_valid = 0;
        for (int k = 0; k < 24; k++) begin
            accepted = (m_st == S_RUN) && (m_phase >= int'(div));
            in_valid = accepted;
            if (accepted) begin
                in_data = DATA_W'(10'h060 + k);
                sent.push_back(in_data);
            end
            cycle();
            if (accepted) chk("d_fill_pp", fill, 3);
        end
        in_valid = 0;
        run(20);
        npop = 0;
        for (int k = 0; k < log_upd.size(); k++) begin
            if ($onehot(log_upd[k])) begin
                tmp = log_code[k];
                ch = log_upd[k][1] ? 1 : 0;
                if (npop < sent.size()) chk("d_order", tmp[ch*DATA_W +: DATA_W], sent[npop]);
                npop++;
            end
        end
        chk("d_pop_count", npop, sent.size());

        // Randomised traffic with live control changes
        vprob = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) vprob = $urandom_range(20, 90);
            enable = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 99) == 0) hold_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) div = DIV_W'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) prime_lvl = (AW+1)'($urandom_range(1, DEPTH));
            in_valid = ($urandom_range(0, 99) < vprob);
            in_data  = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            cycle();
        end

        // Asynchronous reset in RUN with five samples buffered
        enable = 0; in_valid = 0;
        async_reset();
        enable = 1; div = 7; prime_lvl = 5; hold_mode = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = DATA_W'(10'h0A0 + i);
            cycle();
        end
        in_valid = 0;
        run(3);
        chk("f_pre_fill", fill, 5);
        chk("f_pre_clk_en", dac_clk_en, 1);
        async_reset();
        enable = 0;
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_stream_seq.md
DAC_STREAM_SEQ -- requirements
Module: dac_stream_seq

Interface
REQ-001 Parameters (name, default, meaning):
  DATA_W  10  sample width, matches DAC code width
  NCH     2   DAC channel count (1..8)
  DEPTH   8   sample FIFO depth (power of 2, >=2)
  DIV_W   16  sample-rate divider width
REQ-002 Ports (name, direction, width, meaning):
  CLK         in   1             core clock
  reset_n     in   1             async active-low reset
  enable      in   1             run request
  hold_mode   in   1             on underrun: 1 = hold last code, 0 = drive zero code
  div         in   DIV_W         tick period = div+1 CLK cycles; 0 = tick every cycle
  prime_lvl   in   log2(DEPTH)+1 FIFO fill required to leave PRIME (1..DEPTH)
  in_data     in   DATA_W        sample from core
  in_valid    in   1             sample offered
  in_ready    out  1             FIFO can accept
  dac_code    out  NCH*DATA_W    per-channel registered DAC code, ch0 in LSBs
  dac_upd     out  NCH           one-cycle pulse when that channel's code changes source
  dac_clk_en  out  1             enable for the DAC clock gate
  underrun    out  1             sticky underrun flag
  fill        out  log2(DEPTH)+1 current FIFO occupancy
REQ-003 Clock is CLK; reset is reset_n, asynchronous, active-low; single clock domain.

Function
REQ-004 Push occurs when in_valid && in_ready; in_ready = (fill < DEPTH), combinational from registered fill.
REQ-005 Pop occurs only on a tick in RUN with fill > 0; a push and pop in the same cycle leave fill unchanged.
REQ-006 Tick counter counts 0..div and then wraps; tick asserts on the wrap cycle; counter held at 0 outside RUN.
REQ-007 States: IDLE, PRIME, RUN.
REQ-008 IDLE -> PRIME when enable=1.
REQ-009 PRIME -> RUN when fill >= prime_lvl.
REQ-010 RUN -> PRIME on a tick with fill=0 (underrun).
REQ-011 Any state -> IDLE when enable=0, taking effect the next cycle; FIFO contents retained.
REQ-012 Each pop writes the sample to channel ch_ptr, pulses dac_upd[ch_ptr] in the same cycle as the code update, then increments ch_ptr modulo NCH.
REQ-013 Latency: popped sample appears on dac_code one CLK after the tick.
REQ-014 Underrun tick: set underrun; if hold_mode=0, load zero into all channels and pulse all dac_upd bits; if hold_mode=1, leave codes unchanged with no dac_upd pulse; ch_ptr is reset to 0 in both cases.
REQ-015 underrun clears only on reset or on an IDLE -> PRIME transition.
REQ-016 dac_clk_en = 1 in PRIME and RUN, and for exactly one cycle after entering IDLE, so the last code update completes.
REQ-017 fill never exceeds DEPTH and never goes below 0; pointers wrap modulo DEPTH.
REQ-018 div and prime_lvl are sampled live; a change to div mid-count takes effect at the next wrap.

Reset
REQ-019 reset_n low: state=IDLE, FIFO empty (fill=0), pointers, tick counter and ch_ptr = 0, dac_code all 0, dac_upd=0, underrun=0, dac_clk_en=0, in_ready=1.
REQ-020 Reset asserted mid-stream discards all buffered samples; there is no partial-state recovery.

Structure
REQ-021 Shared package holds the state enum (IDLE/PRIME/RUN) and default parameter constants used by the SoC top.
REQ-022 One sub-module, seq_fifo (parametrised DATA_W/DEPTH, reports fill), holds the sample buffer; the FSM, divider and channel demux live in dac_stream_seq.

Verification
REQ-023 Reset then enable=1, div=3, prime_lvl=4, push 4 samples 0x001..0x004, NCH=2 -> RUN after the 4th push; ticks every 4 cycles; ch0=0x001, ch1=0x002, ch0=0x003, ch1=0x004, each with a one-cycle dac_upd pulse.
REQ-024 Push 9 samples with in_valid held high and DEPTH=8, FSM held in PRIME -> in_ready=0 at fill=8; 9th sample accepted only after the first pop.
REQ-025 Drain the FIFO in RUN with hold_mode=0 -> underrun=1, all codes 0, dac_upd=all-ones for one cycle, state returns to PRIME.
REQ-026 Same as REQ-025 with hold_mode=1 -> codes keep their last values, no dac_upd pulse, underrun=1; toggling enable 0->1 clears underrun.
REQ-027 Simultaneous push and pop on a tick at fill=3 -> fill stays 3, data order preserved.
REQ-028 Assert reset_n low mid-RUN with fill=5 -> all outputs at their REQ-019 values immediately (asynchronous), fill=0.
